// File: rtl/dmem_trace_if.sv
// dmem_trace_if: data-bus and write-trace signals between the MIPS core, dmem_trace and the trace consumer
interface dmem_trace_if #(parameter int LOG_DEPTH = 8);
  logic memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic trace_valid;
  logic trace_ready;
  logic [31:0] trace_addr;
  logic [31:0] trace_data;
  logic [$clog2(LOG_DEPTH):0] trace_count;
  logic [15:0] write_count;
  logic overflow;
  logic misaligned;
  modport master (
    output memwrite, dataadr, writedata, trace_ready,
    input readdata, trace_valid, trace_addr, trace_data, trace_count, write_count, overflow, misaligned
  );
  modport slave (
    input memwrite, dataadr, writedata, trace_ready,
    output readdata, trace_valid, trace_addr, trace_data, trace_count, write_count, overflow, misaligned
  );
endinterface

// File: rtl/dmem_trace.sv
// dmem_trace: word RAM data memory with a show-ahead FIFO logging every store's address and data
module dmem_trace #(
  parameter int DEPTH = 64,
  parameter int LOG_DEPTH = 8
) (
  input logic clk,
  input logic reset,
  dmem_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(LOG_DEPTH);
  logic [31:0] ram [DEPTH];
  logic [63:0] fifo [LOG_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic [15:0] wc;
  logic ovf, mis;
  logic [AW-1:0] idx;
  logic full, pop, push;
  always_comb begin
    idx = bus.dataadr[AW+1:2];
    full = cnt == (PW+1)'(LOG_DEPTH);
    pop = (cnt != '0) & bus.trace_ready;
    push = bus.memwrite & (~full | pop);
  end
  always_ff @(posedge clk) begin
    if (bus.memwrite && bus.dataadr[1:0] == 2'b00) ram[idx] <= bus.writedata;
    if (push) fifo[wp] <= {bus.dataadr, bus.writedata};
  end
  // A pop on a full FIFO frees the slot the coincident push needs, so no overflow then
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      wc <= '0;
      ovf <= 1'b0;
      mis <= 1'b0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      if (bus.memwrite && wc != 16'hFFFF) wc <= wc + 16'd1;
      if (bus.memwrite && full && !pop) ovf <= 1'b1;
      if (bus.memwrite && bus.dataadr[1:0] != 2'b00) mis <= 1'b1;
    end
  end
  always_comb begin
    bus.readdata = ram[idx];
    bus.trace_valid = cnt != '0;
    bus.trace_addr = fifo[rp][63:32];
    bus.trace_data = fifo[rp][31:0];
    bus.trace_count = cnt;
    bus.write_count = wc;
    bus.overflow = ovf;
    bus.misaligned = mis;
  end
endmodule

// File: tb/tb_dmem_trace.sv
// tb_dmem_trace: store/trace bench with a scoreboard of expected trace entries
module tb_dmem_trace;
  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;
  dmem_trace_if #(.LOG_DEPTH(8)) bus();
  dmem_trace #(.DEPTH(64), .LOG_DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mram [64];
  logic [63:0] sb [$];
  int mwc = 0;
  bit movf = 0;
  bit mmis = 0;
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] radr;
    logic [31:0] rexp;
  } vec_t;
  vec_t vt [3];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic chk_state(input string nm);
    chk({nm, ".valid"}, 32'(bus.trace_valid), 32'(sb.size() != 0));
    chk({nm, ".count"}, 32'(bus.trace_count), 32'(sb.size()));
    chk({nm, ".write_count"}, 32'(bus.write_count), 32'(mwc));
    chk({nm, ".overflow"}, 32'(bus.overflow), 32'(movf));
    chk({nm, ".misaligned"}, 32'(bus.misaligned), 32'(mmis));
  endtask
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    #2;
    reset = 0;
    sb.delete();
    mwc = 0;
    movf = 0;
    mmis = 0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memwrite = 1;
    bus.dataadr = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    bus.memwrite = 0;
    if (a[1:0] == 2'b00) mram[a[7:2]] = d;
    if (mwc < 65535) mwc++;
    if (a[1:0] != 2'b00) mmis = 1;
    if (sb.size() < 8) sb.push_back({a, d});
    else movf = 1;
  endtask
  task automatic load(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.memwrite = 0;
    bus.dataadr = a;
    #1;
    chk(nm, bus.readdata, exp);
  endtask
  task automatic drain_one(input string nm);
    logic [63:0] e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: drain with empty scoreboard", nm);
    end else begin
      e = sb.pop_front();
      chk({nm, ".head_valid"}, 32'(bus.trace_valid), 32'd1);
      chk({nm, ".head_addr"}, bus.trace_addr, e[63:32]);
      chk({nm, ".head_data"}, bus.trace_data, e[31:0]);
      bus.trace_ready = 1;
      @(posedge clk);
      #1;
      bus.trace_ready = 0;
    end
  endtask
  task automatic drain_all(input string nm);
    while (sb.size() > 0) drain_one(nm);
    chk({nm, ".empty_valid"}, 32'(bus.trace_valid), 32'd0);
    chk({nm, ".empty_count"}, 32'(bus.trace_count), 32'd0);
  endtask
  initial begin
    logic [63:0] e;
    bus.memwrite = 0;
    bus.dataadr = 0;
    bus.writedata = 0;
    bus.trace_ready = 0;
    vt[0] = '{32'h50, 32'hAA, 32'h50, 32'hAA};
    vt[1] = '{32'h52, 32'hBB, 32'h50, 32'hAA};
    vt[2] = '{32'h100, 32'h1234, 32'h0, 32'h1234};
    do_reset();
    chk_state("reset");
    store(32'h50, 32'h7);
    store(32'h54, 32'h7);
    load("basic.rd50", 32'h50, 32'h7);
    load("basic.rd54", 32'h54, 32'h7);
    chk_state("basic");
    chk("basic.count2", 32'(bus.trace_count), 32'd2);
    chk("basic.head_addr0", bus.trace_addr, 32'h50);
    drain_all("basic");
    for (int i = 0; i < 3; i++) begin
      store(vt[i].adr, vt[i].dat);
      load($sformatf("vec%0d.rd", i), vt[i].radr, vt[i].rexp);
      chk_state($sformatf("vec%0d", i));
    end
    chk("vec.misaligned", 32'(bus.misaligned), 32'd1);
    drain_all("vec");
    bus.trace_ready = 1;
    @(posedge clk);
    #1;
    bus.trace_ready = 0;
    chk_state("pop_empty");
    do_reset();
    for (int i = 0; i < 9; i++) store(32'(4 * i), 32'(i + 1));
    chk_state("ovf");
    chk("ovf.count8", 32'(bus.trace_count), 32'd8);
    chk("ovf.flag", 32'(bus.overflow), 32'd1);
    load("ovf.rd20", 32'h20, 32'd9);
    drain_all("ovf");
    do_reset();
    for (int i = 0; i < 8; i++) store(32'h80 + 32'(4 * i), 32'h100 + 32'(i));
    e = sb.pop_front();
    chk("sim.head_addr", bus.trace_addr, e[63:32]);
    chk("sim.head_data", bus.trace_data, e[31:0]);
    bus.memwrite = 1;
    bus.dataadr = 32'h200;
    bus.writedata = 32'h999;
    bus.trace_ready = 1;
    @(posedge clk);
    #1;
    bus.memwrite = 0;
    bus.trace_ready = 0;
    mram[0] = 32'h999;
    mwc++;
    sb.push_back({32'h200, 32'h999});
    chk_state("sim");
    chk("sim.count8", 32'(bus.trace_count), 32'd8);
    chk("sim.no_ovf", 32'(bus.overflow), 32'd0);
    drain_all("sim");
    do_reset();
    for (int i = 0; i < 9; i++) store(32'h40 + 32'(4 * i), 32'hC0 + 32'(i));
    for (int i = 0; i < 5; i++) drain_one("mid.pre");
    chk_state("mid.pre");
    @(posedge clk);
    #1;
    reset = 1;
    #1;
    chk("mid.valid", 32'(bus.trace_valid), 32'd0);
    chk("mid.count", 32'(bus.trace_count), 32'd0);
    chk("mid.write_count", 32'(bus.write_count), 32'd0);
    chk("mid.overflow", 32'(bus.overflow), 32'd0);
    #1;
    reset = 0;
    sb.delete();
    mwc = 0;
    movf = 0;
    mmis = 0;
    load("mid.rd40", 32'h40, 32'hC0);
    load("mid.rd60", 32'h60, 32'hC8);
    load("mid.rd00", 32'h0, mram[0]);
    store(32'h70, 32'h55);
    chk_state("post");
    load("post.rd70", 32'h70, 32'h55);
    drain_all("post");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
